// File: rtl/food_placer_if.sv
// Signal bundle between the food placer and its environment: game FSM
// request/status, LFSR value and reseed strobe, occupancy RAM read port.
// master = environment side (requester, LFSR, RAM); slave = food_placer.
interface food_placer_if;
   logic        place_req;
   logic [8:0]  rand_num;
   logic        lfsr_load;
   logic [11:0] lfsr_seed;
   logic [8:0]  occ_addr;
   logic        occ_hit;
   logic [8:0]  food_pos;
   logic        food_valid;
   logic        busy;
   logic        done;
   logic        grid_full;

   modport master (
      output place_req, rand_num, occ_hit,
      input  lfsr_load, lfsr_seed, occ_addr, food_pos, food_valid, busy, done, grid_full
   );

   modport slave (
      input  place_req, rand_num, occ_hit,
      output lfsr_load, lfsr_seed, occ_addr, food_pos, food_valid, busy, done, grid_full
   );
endinterface

// File: rtl/food_placer.sv
// Food placement controller for the snake game.
// Draws random cell indices from the LFSR, rejects out-of-range or occupied
// cells, and after MAX_TRIES random samples falls back to a wrap-around scan
// of the occupancy map. Occupancy RAM read data arrives two cycles after the
// address changes, hence the WAIT state between address and CHECK.
// Optional feature: define FOOD_SEED_EN to reseed the LFSR from a free-running
// counter on the first request after reset.
module food_placer #(
   parameter int GRID_CELLS = 300,
   parameter int MAX_TRIES  = 32
) (
   input  logic         clk,
   input  logic         rst,
   food_placer_if.slave bus
);

   localparam int              TW         = $clog2(MAX_TRIES + 1);
   localparam logic [9:0]      GRID_LIMIT = 10'(GRID_CELLS);
   localparam logic [TW-1:0]   TRY_LIMIT  = TW'(MAX_TRIES);

`ifdef FOOD_SEED_EN
   typedef enum logic [2:0] {IDLE, SEED, SAMPLE, WAIT, CHECK, SCAN} state_t;
`else
   typedef enum logic [2:0] {IDLE, SAMPLE, WAIT, CHECK, SCAN} state_t;
`endif

   state_t        state;
   logic [8:0]    cand;
   logic [TW-1:0] tries;
   logic [9:0]    probes;
   logic          scan_mode;
   logic [8:0]    occ_addr_q;
   logic [8:0]    food_pos_q;
   logic          food_valid_q;
   logic          busy_q;
   logic          done_q;
   logic          grid_full_q;

   // All range comparisons are done on 10-bit zero-extended values so that
   // cand+1 from 511 cannot alias back into range.
   logic [9:0]    rand_ext;
   logic [9:0]    cand_ext;
   logic [9:0]    cand_inc;
   logic [9:0]    scan_next;
   logic [TW-1:0] tries_inc;

   assign rand_ext  = {1'b0, bus.rand_num};
   assign cand_ext  = {1'b0, cand};
   assign cand_inc  = cand_ext + 10'd1;
   assign tries_inc = tries + TW'(1);

   // Next scan candidate: start at 0 if random mode ended on an out-of-range
   // value, otherwise step forward with wrap at the end of the grid.
   always_comb begin
      scan_next = cand_inc;
      if ((probes == 10'd0) && (cand_ext >= GRID_LIMIT))
         scan_next = 10'd0;
      else if (cand_inc >= GRID_LIMIT)
         scan_next = 10'd0;
   end

`ifdef FOOD_SEED_EN
   logic [11:0] counter;
   logic        seed_pending;
   logic        lfsr_load_q;
   logic [11:0] lfsr_seed_q;

   // Free-running entropy source sampled when the LFSR is reseeded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) counter <= 12'd0;
      else     counter <= counter + 12'd1;
   end

   assign bus.lfsr_load = lfsr_load_q;
   assign bus.lfsr_seed = lfsr_seed_q;
`else
   assign bus.lfsr_load = 1'b0;
   assign bus.lfsr_seed = 12'd0;
`endif

   // Placement FSM with registered status outputs; busy and done are
   // computed from the transition so they line up with the state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cand         <= 9'd0;
         tries        <= '0;
         probes       <= 10'd0;
         scan_mode    <= 1'b0;
         occ_addr_q   <= 9'd0;
         food_pos_q   <= 9'd0;
         food_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         grid_full_q  <= 1'b0;
`ifdef FOOD_SEED_EN
         seed_pending <= 1'b1;
         lfsr_load_q  <= 1'b0;
         lfsr_seed_q  <= 12'd0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef FOOD_SEED_EN
         lfsr_load_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.place_req) begin
                  food_valid_q <= 1'b0;
                  grid_full_q  <= 1'b0;
                  tries        <= '0;
                  scan_mode    <= 1'b0;
                  busy_q       <= 1'b1;
`ifdef FOOD_SEED_EN
                  if (seed_pending) begin
                     seed_pending <= 1'b0;
                     lfsr_load_q  <= 1'b1;
                     lfsr_seed_q  <= (counter[8:0] == 9'd0) ? 12'd1 : counter;
                     state        <= SEED;
                  end else begin
                     state <= SAMPLE;
                  end
`else
                  state <= SAMPLE;
`endif
               end
            end
`ifdef FOOD_SEED_EN
            SEED: state <= SAMPLE;
`endif
            SAMPLE: begin
               cand  <= bus.rand_num;
               tries <= tries_inc;
               if (rand_ext >= GRID_LIMIT) begin
                  if (tries_inc == TRY_LIMIT) begin
                     scan_mode <= 1'b1;
                     probes    <= 10'd0;
                     state     <= SCAN;
                  end
               end else begin
                  occ_addr_q <= bus.rand_num;
                  state      <= WAIT;
               end
            end
            WAIT: state <= CHECK;
            CHECK: begin
               if (!bus.occ_hit) begin
                  food_pos_q   <= cand;
                  food_valid_q <= 1'b1;
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  state        <= IDLE;
               end else if (!scan_mode) begin
                  if (tries == TRY_LIMIT) begin
                     scan_mode <= 1'b1;
                     probes    <= 10'd0;
                     state     <= SCAN;
                  end else begin
                     state <= SAMPLE;
                  end
               end else if (probes == GRID_LIMIT) begin
                  grid_full_q <= 1'b1;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               occ_addr_q <= scan_next[8:0];
               cand       <= scan_next[8:0];
               probes     <= probes + 10'd1;
               state      <= WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.occ_addr   = occ_addr_q;
   assign bus.food_pos   = food_pos_q;
   assign bus.food_valid = food_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.grid_full  = grid_full_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed testbench for food_placer (GRID_CELLS=300, MAX_TRIES=32).
// Models the occupancy RAM as a one-cycle registered read of a local map.
// With FOOD_SEED_EN defined, the reseed behaviour is also exercised.
module tb_food_placer;

   logic clk;
   logic rst;
   int   n_compared;
   int   n_mismatched;
   int   cyc;
   logic occ_map [0:511];

`ifdef FOOD_SEED_EN
   localparam int SEED_EXTRA = 1;
`else
   localparam int SEED_EXTRA = 0;
`endif

   food_placer_if bus ();

   food_placer #(.GRID_CELLS(300), .MAX_TRIES(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 100 MHz-style clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Occupancy RAM with registered read: hit follows the address by one edge.
   always @(posedge clk) bus.occ_hit <= occ_map[bus.occ_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_map(input int lo, input int hi);
      for (int i = 0; i < 512; i++) occ_map[i] = 1'b0;
      for (int i = lo; i <= hi; i++) occ_map[i] = 1'b1;
   endtask

   // Issue a one-cycle request and count cycles from the request edge to done.
   task automatic run_request(input int bound, output int cycles);
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < bound) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.place_req = 1'b0;
      bus.rand_num = 9'd57;
      #3;
      n_compared++;
      if ({bus.busy, bus.done, bus.food_valid, bus.grid_full, bus.lfsr_load} !== 5'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_flags: got %b expected 00000",
                  {bus.busy, bus.done, bus.food_valid, bus.grid_full, bus.lfsr_load});
      end
      n_compared++;
      if (bus.food_pos !== 9'd0 || bus.occ_addr !== 9'd0 || bus.lfsr_seed !== 12'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_values: got pos=%0d addr=%0d seed=%0d expected 0/0/0",
                  bus.food_pos, bus.occ_addr, bus.lfsr_seed);
      end
      tick();
      rst = 1'b0;
   endtask

`ifdef FOOD_SEED_EN
   task automatic test_seed();
      set_map(1, 0);
      bus.rand_num = 9'd57;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (512) @(posedge clk);
      #1;
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      n_compared++;
      if (bus.lfsr_load !== 1'b1 || bus.lfsr_seed !== 12'd1) begin
         n_mismatched++;
         $display("[TB] FAIL seed_first: got load=%0d seed=%0d expected load=1 seed=1",
                  bus.lfsr_load, bus.lfsr_seed);
      end
      tick();
      n_compared++;
      if (bus.lfsr_load !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL seed_pulse_width: got %0d expected 0", bus.lfsr_load);
      end
      repeat (3) tick();
      n_compared++;
      if (bus.done !== 1'b1 || bus.food_pos !== 9'd57) begin
         n_mismatched++;
         $display("[TB] FAIL seed_done: got done=%0d pos=%0d expected done=1 pos=57",
                  bus.done, bus.food_pos);
      end
      tick();
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      n_compared++;
      if (bus.lfsr_load !== 1'b0 || bus.busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL seed_second: got load=%0d busy=%0d expected load=0 busy=1",
                  bus.lfsr_load, bus.busy);
      end
      repeat (4) tick();
   endtask
`endif

   task automatic test_free_sample();
      set_map(1, 0);
      bus.rand_num = 9'd57;
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      n_compared++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL free_e0: got busy=%0d done=%0d expected busy=1 done=0", bus.busy, bus.done);
      end
      tick();
      n_compared++;
      if (bus.occ_addr !== 9'd57) begin
         n_mismatched++;
         $display("[TB] FAIL free_occ_addr: got %0d expected 57", bus.occ_addr);
      end
      tick();
      n_compared++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL free_e2: got busy=%0d done=%0d expected busy=1 done=0", bus.busy, bus.done);
      end
      tick();
      n_compared++;
      if (bus.done !== 1'b1 || bus.food_valid !== 1'b1 || bus.food_pos !== 9'd57 || bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL free_e3: got done=%0d valid=%0d pos=%0d busy=%0d expected 1/1/57/0",
                  bus.done, bus.food_valid, bus.food_pos, bus.busy);
      end
      tick();
      n_compared++;
      if (bus.done !== 1'b0 || bus.food_valid !== 1'b1 || bus.lfsr_load !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL free_after: got done=%0d valid=%0d load=%0d expected 0/1/0",
                  bus.done, bus.food_valid, bus.lfsr_load);
      end
   endtask

   task automatic test_scan_fallback();
      set_map(0, 4);
      bus.rand_num = 9'd400;
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      n_compared++;
      if (bus.food_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL scan_valid_cleared: got %0d expected 0", bus.food_valid);
      end
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      n_compared++;
      if (cyc !== 50 || bus.food_pos !== 9'd5 || bus.food_valid !== 1'b1 || bus.grid_full !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL scan_result: got cyc=%0d pos=%0d valid=%0d full=%0d expected 50/5/1/0",
                  cyc, bus.food_pos, bus.food_valid, bus.grid_full);
      end
      repeat (3) tick();
      n_compared++;
      if (bus.occ_addr !== 9'd5) begin
         n_mismatched++;
         $display("[TB] FAIL idle_addr_hold: got %0d expected 5", bus.occ_addr);
      end
   endtask

   task automatic test_boundary();
      set_map(1, 0);
      bus.rand_num = 9'd299;
      run_request(200, cyc);
      n_compared++;
      if (cyc !== 3 || bus.food_pos !== 9'd299) begin
         n_mismatched++;
         $display("[TB] FAIL bound_299: got cyc=%0d pos=%0d expected 3/299", cyc, bus.food_pos);
      end
      tick();
      bus.rand_num = 9'd300;
      run_request(200, cyc);
      n_compared++;
      if (cyc !== 35 || bus.food_pos !== 9'd0) begin
         n_mismatched++;
         $display("[TB] FAIL bound_300: got cyc=%0d pos=%0d expected 35/0", cyc, bus.food_pos);
      end
      tick();
      set_map(298, 299);
      bus.rand_num = 9'd298;
      run_request(300, cyc);
      n_compared++;
      if (cyc !== 102 || bus.food_pos !== 9'd0) begin
         n_mismatched++;
         $display("[TB] FAIL scan_wrap: got cyc=%0d pos=%0d expected 102/0", cyc, bus.food_pos);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      set_map(0, 4);
      bus.rand_num = 9'd400;
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
         bus.place_req = (cyc == 10 || cyc == 40) ? 1'b1 : 1'b0;
      end
      bus.place_req = 1'b0;
      n_compared++;
      if (cyc !== 50 || bus.food_pos !== 9'd5) begin
         n_mismatched++;
         $display("[TB] FAIL busy_req_ignored: got cyc=%0d pos=%0d expected 50/5", cyc, bus.food_pos);
      end
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      n_compared++;
      if (bus.busy !== 1'b1 || bus.food_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL req_in_done_cycle: got busy=%0d valid=%0d expected 1/0", bus.busy, bus.food_valid);
      end
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      n_compared++;
      if (cyc !== 50 || bus.food_pos !== 9'd5) begin
         n_mismatched++;
         $display("[TB] FAIL back_to_back_result: got cyc=%0d pos=%0d expected 50/5", cyc, bus.food_pos);
      end
      tick();
   endtask

   task automatic test_full_grid();
      set_map(0, 299);
      bus.rand_num = 9'd10;
      run_request(1200, cyc);
      n_compared++;
      if (cyc !== 996) begin
         n_mismatched++;
         $display("[TB] FAIL full_latency: got %0d expected 996", cyc);
      end
      n_compared++;
      if (bus.grid_full !== 1'b1 || bus.food_valid !== 1'b0 || bus.food_pos !== 9'd5 || bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL full_flags: got full=%0d valid=%0d pos=%0d busy=%0d expected 1/0/5/0",
                  bus.grid_full, bus.food_valid, bus.food_pos, bus.busy);
      end
      tick();
      n_compared++;
      if (bus.done !== 1'b0 || bus.grid_full !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL full_hold: got done=%0d full=%0d expected 0/1", bus.done, bus.grid_full);
      end
   endtask

   task automatic test_reset_mid_scan();
      set_map(0, 4);
      bus.rand_num = 9'd400;
      bus.place_req = 1'b1;
      tick();
      bus.place_req = 1'b0;
      repeat (40) tick();
      #2;
      rst = 1'b1;
      #1;
      n_compared++;
      if ({bus.busy, bus.done, bus.food_valid, bus.grid_full} !== 4'b0 ||
          bus.food_pos !== 9'd0 || bus.occ_addr !== 9'd0) begin
         n_mismatched++;
         $display("[TB] FAIL mid_reset: got flags=%b pos=%0d addr=%0d expected 0000/0/0",
                  {bus.busy, bus.done, bus.food_valid, bus.grid_full}, bus.food_pos, bus.occ_addr);
      end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      n_compared++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL post_reset_idle: got done=%0d busy=%0d expected 0/0", bus.done, bus.busy);
      end
      set_map(1, 0);
      bus.rand_num = 9'd57;
      run_request(50, cyc);
      n_compared++;
      if (cyc !== 3 + SEED_EXTRA || bus.food_pos !== 9'd57 || bus.food_valid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL post_reset_request: got cyc=%0d pos=%0d valid=%0d expected %0d/57/1",
                  cyc, bus.food_pos, bus.food_valid, 3 + SEED_EXTRA);
      end
      tick();
   endtask

   // Test sequence.
   initial begin
      n_compared = 0;
      n_mismatched = 0;
      for (int i = 0; i < 512; i++) occ_map[i] = 1'b0;
      test_reset();
`ifdef FOOD_SEED_EN
      test_seed();
`endif
      test_free_sample();
      test_scan_fallback();
      test_boundary();
      test_back_to_back();
      test_full_grid();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Global watchdog in case a wait loop is never released.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/food_placer.md
# food_placer

Food placement controller for the snake game. On request, it draws cell indices from the 9-bit LFSR random generator and checks each candidate against the snake-body occupancy map. It rejects out-of-range or occupied cells and falls back to a deterministic wrap-around scan after a bounded number of random tries. It sits between the game FSM (requester), the LFSR (sequenced/seeded resource) and the occupancy RAM (read port).

## Interface

**Parameters**
- `GRID_CELLS`, default 300: number of valid cells; legal indices are 0..GRID_CELLS-1, and the value must be ≤512.
- `MAX_TRIES`, default 32: random samples allowed before switching to scan mode.

**Ports**
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `place_req`  in  1  request to place new food; accepted only in IDLE.
- `rand_num`  in  9  current LFSR output; the LFSR free-runs one step per clock.
- `lfsr_load`  out  1  one-cycle LFSR reseed strobe.
- `lfsr_seed`  out  12  seed value for the LFSR.
- `occ_addr`  out  9  occupancy RAM read address (registered).
- `occ_hit`  in  1  cell occupied; valid in the second cycle after `occ_addr` changes (RAM with registered read).
- `food_pos`  out  9  placed food cell index.
- `food_valid`  out  1  `food_pos` holds a legal free cell.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a placement attempt ends.
- `grid_full`  out  1  last attempt found no free cell.

## Operation

**Reset values:** all outputs are 0; state is IDLE; `tries` is 0; `cand` is 0.

**States:** IDLE, SEED (only with the macro defined), SAMPLE, WAIT, CHECK, SCAN.

- **IDLE**
  - On `place_req`: clear `food_valid` and `grid_full`, and zero `tries`.
  - Go to SEED if seeding is pending, otherwise go to SAMPLE.
- **SAMPLE**
  - Set `cand <= rand_num` and `tries <= tries+1`.
  - If `rand_num ≥ GRID_CELLS`: stay in SAMPLE, unless `tries+1 == MAX_TRIES`, in which case go to SCAN.
  - Otherwise set `occ_addr <= rand_num` and go to WAIT.
- **WAIT:** unconditionally go to CHECK.
- **CHECK**
  - If `!occ_hit`:
    - Set `food_pos <= cand` and `food_valid <= 1`.
    - Pulse `done`.
    - Go to IDLE.
  - Else, in random mode:
    - If `tries == MAX_TRIES`, go to SCAN.
    - Otherwise go to SAMPLE.
  - Else, in scan mode:
    - If `probes == GRID_CELLS`, set `grid_full <= 1`, pulse `done`, and go to IDLE.
    - Otherwise go to SCAN.
- **SCAN**
  - Next candidate:
    - If this is the first scan probe and the last `cand` was out of range, the next candidate is 0.
    - Otherwise it is `cand+1`, wrapping from GRID_CELLS-1 to 0.
  - Set `occ_addr <= next`, `cand <= next`, and `probes <= probes+1`.
  - Go to WAIT.
  - `probes` is 10 bits and is zeroed on entry to scan mode.

**Rules**
- `place_req` is ignored while `busy` is high.
- `done` is asserted in the first IDLE cycle, so a `place_req` in the same cycle as `done` is accepted.
- `food_pos` holds its previous value on a failed (full) attempt.
- `occ_addr` holds its value in IDLE.
- Compare against GRID_CELLS using unsigned 10-bit arithmetic, so the 511+1 wrap is never ambiguous.

## Timing

- `place_req` is sampled at edge E0 and the state becomes SAMPLE.
- With an in-range, free first sample:
  - `occ_addr` updates at E1.
  - CHECK runs in the cycle after E2.
  - `food_pos`, `food_valid` and `done` are visible after E3.
- Best-case latency is 3 cycles from the request edge to `done`, plus 1 cycle when SEED runs.
- Cost per step:
  - Each out-of-range sample costs 1 cycle.
  - Each occupied in-range sample costs 3 cycles.
  - Each scan probe costs 3 cycles.
- Worst case is MAX_TRIES×3 + GRID_CELLS×3 + 1 cycles.
- Reset asserted mid-operation: outputs return to reset values asynchronously, and no `done` pulse is produced.

## Configuration

**`FOOD_SEED_EN`**
- When defined:
  - A free-running 12-bit counter runs from reset.
  - The first accepted `place_req` after reset enters SEED for one cycle, driving `lfsr_load=1` and `lfsr_seed=counter`.
  - If `counter[8:0]==0`, `lfsr_seed` is 12'd1 instead, so the all-zero LFSR lock-up state is never loaded.
  - SEED then goes to SAMPLE; later requests skip SEED.
- When undefined:
  - The SEED state and the counter are absent.
  - `lfsr_load` and `lfsr_seed` are tied to 0.

## Test plan

- **Free first sample:** `rand_num` held at 57, empty map, `place_req` at E0 → `done` and `food_valid=1` after E3, `food_pos=57`, `busy` high for 3 cycles.
- **Scan fallback:** `rand_num` held at 400, cells 0–4 occupied → 32 samples, then scan from 0 → `food_pos=5` with `done` at cycle 32 + 6×3 = 50.
- **Full grid:** all 300 cells occupied, `rand_num=10` → after 32×3 + 300×3 cycles `done` pulses, `grid_full=1`, `food_valid=0`, and `food_pos` is unchanged.
- **Request handling:** `place_req` while `busy` → ignored, `tries` unaffected; `place_req` in the `done` cycle → accepted, `busy=1` next cycle.
- **Reset mid-scan:** `rst` asserted during scan → all outputs 0 immediately; after release, a `place_req` works normally.
- **Seeding (`FOOD_SEED_EN`):** first request with counter=0x200 → one `lfsr_load` pulse with `lfsr_seed=12'd1`; a second request produces no `lfsr_load`.
